// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte FIFO plus sequencer sitting directly upstream of uart_tx. Bytes written
// by the core are queued, then handed to uart_tx one at a time using its
// trigger/data/done handshake. A push into a full FIFO and a transmitter that
// never reports done are both reported through sticky flags.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  cycles allowed in S_WAIT for tx_done_i (>= 12)
//
// Ports
//   clk_i         clock, everything on the rising edge
//   reset_i       synchronous active-high reset
//   wr_en_i       push wr_data_i this cycle
//   wr_data_i     byte to transmit
//   wr_ready_o    FIFO not full, a push this cycle is accepted
//   fifo_count_o  number of bytes held in the FIFO
//   fifo_empty_o  FIFO holds no bytes
//   overflow_o    sticky: a push was attempted while full
//   ovf_clr_i     clears overflow_o and timeout_o (wins over a same-cycle set)
//   tx_trigger_o  one-cycle start pulse to uart_tx
//   tx_data_o     byte for uart_tx, changes only when a byte is popped
//   tx_busy_i     uart_tx busy
//   tx_done_i     uart_tx done, one cycle during the stop bit
//   timeout_o     sticky: uart_tx did not report done in time
//   idle_o        FIFO empty and sequencer idle
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter  int DEPTH       = 16,
  parameter  int TIMEOUT_CYC = 32,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          wr_ready_o,
  output logic [CW-1:0] fifo_count_o,
  output logic          fifo_empty_o,
  output logic          overflow_o,
  input  logic          ovf_clr_i,
  output logic          tx_trigger_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_busy_i,
  input  logic          tx_done_i,
  output logic          timeout_o,
  output logic          idle_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] timer_q;
  logic          trigger;
  logic          timeout_set;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A push into a full FIFO is dropped even if a pop frees a slot in the same
  // cycle: full is taken from registered state, so there is no pass-through.
  assign push = wr_en_i & ~full;
  // Pop only from S_IDLE; since count_q is registered a freshly pushed byte
  // is visible to the sequencer one cycle later (no fall-through).
  assign pop  = (state_q == S_IDLE) & ~empty;

  // NOTE: the byte array carries no reset; the pointers and count define
  // which entries are valid, so clearing storage would only cost area.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // tx_data_o only moves on a pop, so it stays stable while uart_tx captures
  // and shifts the byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_data_o <= 8'h00;
    end else if (pop) begin
      tx_data_o <= mem[rd_ptr_q];
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    trigger     = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_TRIG;
      end
      S_TRIG: begin
        // Hold the popped byte until uart_tx is free, then fire once.
        if (!tx_busy_i) begin
          trigger = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // done wins over a timeout seen in the same cycle.
        if (tx_done_i) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counts cycles spent in S_WAIT; cleared by the trigger. Saturates instead
  // of wrapping so a stuck value can never alias back to a small count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_q <= '0;
    end else if (trigger) begin
      timer_q <= '0;
    end else if ((state_q == S_WAIT) && (timer_q != '1)) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky status flags; the clear request has priority over a new event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else if (ovf_clr_i) begin
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (wr_en_i && full) overflow_o <= 1'b1;
      if (timeout_set)     timeout_o  <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wr_ready_o   = ~full;
  assign fifo_count_o = count_q;
  assign fifo_empty_o = empty;
  assign tx_trigger_o = trigger;
  assign idle_o       = empty & (state_q == S_IDLE);

endmodule
